// File: rtl/aes_block_scheduler_if.sv
// Handshake bundle between the block scheduler, the input FIFO, the AES core
// and the output FIFO. The scheduler uses the master view; the environment uses the slave view.
interface aes_block_scheduler_if;
   logic         in_empty;
   logic [127:0] in_dout;
   logic         in_read_en;
   logic [127:0] aes_din;
   logic         aes_start;
   logic         aes_done;
   logic [127:0] aes_dout;
   logic         out_overflow;
   logic [127:0] out_din;
   logic         out_write_en;

   modport master (
      input  in_empty, in_dout, aes_done, aes_dout, out_overflow,
      output in_read_en, aes_din, aes_start, out_din, out_write_en
   );

   modport slave (
      output in_empty, in_dout, aes_done, aes_dout, out_overflow,
      input  in_read_en, aes_din, aes_start, out_din, out_write_en
   );
endinterface

// File: rtl/aes_block_scheduler.sv
// Moves 128-bit blocks from an input FIFO through an AES core into an output FIFO,
// pacing the FIFO strobes and guarding the core with a completion timeout.
module aes_block_scheduler #(
   parameter int SETTLE_CYC = 2,
   parameter int POP_HOLD   = 3,
   parameter int TIMEOUT    = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   aes_block_scheduler_if.master  bus,
   output logic                   busy,
   output logic                   timeout_err,
   output logic [15:0]            blocks_done
);

   localparam int WAIT_MAX = (SETTLE_CYC > POP_HOLD) ? SETTLE_CYC : POP_HOLD;
   localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYC - 1);
   localparam logic [WAIT_W-1:0] HOLD_LAST   = WAIT_W'(POP_HOLD - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      POP,
      POP_WAIT,
      START,
      CRYPT,
      STORE,
      WRITE,
      WR_WAIT
   } state_t;

   state_t              state_reg;
   logic [127:0]        block_reg;
   logic [WAIT_W-1:0]   wait_cnt_reg;
   logic [TMO_W-1:0]    tmo_cnt_reg;

   assign bus.aes_din = block_reg;

   // Strobes and busy are set on the transition into their state so every output is a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         block_reg        <= '0;
         wait_cnt_reg     <= '0;
         tmo_cnt_reg      <= '0;
         bus.in_read_en   <= 1'b0;
         bus.aes_start    <= 1'b0;
         bus.out_write_en <= 1'b0;
         bus.out_din      <= '0;
         busy             <= 1'b0;
         timeout_err      <= 1'b0;
         blocks_done      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (enable && !bus.in_empty) begin
                  state_reg    <= SETTLE;
                  wait_cnt_reg <= '0;
                  busy         <= 1'b1;
               end
            end
            SETTLE: begin
               if (bus.in_empty) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end else if (wait_cnt_reg == SETTLE_LAST) begin
                  state_reg <= CAPTURE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
               end
            end
            CAPTURE: begin
               block_reg      <= bus.in_dout;
               state_reg      <= POP;
               bus.in_read_en <= 1'b1;
            end
            POP: begin
               bus.in_read_en <= 1'b0;
               wait_cnt_reg   <= '0;
               state_reg      <= POP_WAIT;
            end
            POP_WAIT: begin
               if (wait_cnt_reg == HOLD_LAST) begin
                  state_reg     <= START;
                  bus.aes_start <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
               end
            end
            START: begin
               bus.aes_start <= 1'b0;
               tmo_cnt_reg   <= '0;
               state_reg     <= CRYPT;
            end
            CRYPT: begin
               // A done in the last allowed cycle still wins over the timeout.
               if (bus.aes_done) begin
                  bus.out_din <= bus.aes_dout;
                  state_reg   <= STORE;
               end else if (tmo_cnt_reg == TMO_LAST) begin
                  timeout_err <= 1'b1;
                  state_reg   <= IDLE;
                  busy        <= 1'b0;
               end else begin
                  tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
               end
            end
            STORE: begin
               if (!bus.out_overflow) begin
                  state_reg        <= WRITE;
                  bus.out_write_en <= 1'b1;
               end
            end
            WRITE: begin
               bus.out_write_en <= 1'b0;
               blocks_done      <= blocks_done + 16'd1;
               wait_cnt_reg     <= '0;
               state_reg        <= WR_WAIT;
            end
            WR_WAIT: begin
               if (wait_cnt_reg == HOLD_LAST) begin
                  state_reg <= IDLE;
                  busy      <= 1'b0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
               end
            end
            default: begin
               state_reg        <= IDLE;
               busy             <= 1'b0;
               bus.in_read_en   <= 1'b0;
               bus.aes_start    <= 1'b0;
               bus.out_write_en <= 1'b0;
            end
         endcase
      end
   end

   a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
      $onehot0({bus.in_read_en, bus.aes_start, bus.out_write_en}));
   a_read_in_pop: assert property (@(posedge clk) disable iff (reset)
      bus.in_read_en |-> (state_reg == POP));
   a_start_in_start: assert property (@(posedge clk) disable iff (reset)
      bus.aes_start |-> (state_reg == START));
   a_write_in_write: assert property (@(posedge clk) disable iff (reset)
      bus.out_write_en |-> (state_reg == WRITE));

endmodule

// File: tb/tb_aes_block_scheduler.sv
// Directed bench: FIFO and AES-core models around the scheduler, a vector table
// for plain blocks, and hand-written sequences for the multi-cycle corner cases.
module tb_aes_block_scheduler;

   localparam int SETTLE_CYC = 2;
   localparam int POP_HOLD   = 3;
   localparam int TIMEOUT    = 64;
   localparam logic [127:0] MASK = 128'h5A5A_0F0F_F0F0_A5A5_1234_5678_9ABC_DEF0;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        busy;
   logic        timeout_err;
   logic [15:0] blocks_done;

   aes_block_scheduler_if bif();

   aes_block_scheduler #(
      .SETTLE_CYC(SETTLE_CYC),
      .POP_HOLD  (POP_HOLD),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .bus        (bif),
      .busy       (busy),
      .timeout_err(timeout_err),
      .blocks_done(blocks_done)
   );

   always #5 clk = ~clk;

   // Input FIFO model
   logic [127:0] fifo_mem [0:15];
   int           wr_ptr = 0;
   int           rd_ptr = 0;
   logic         fifo_kill = 1'b0;
   assign bif.in_empty = (wr_ptr == rd_ptr) || fifo_kill;
   assign bif.in_dout  = fifo_mem[rd_ptr[3:0]];
   always @(posedge clk) if (bif.in_read_en) rd_ptr <= rd_ptr + 1;

   // Output FIFO full flag
   logic ovf = 1'b0;
   assign bif.out_overflow = ovf;

   // AES core model: done arrives aes_lat cycles after the start cycle; aes_lat = 0 never answers
   int           aes_lat = 10;
   logic         xor_mode = 1'b0;
   logic [127:0] aes_fixed = '0;
   logic         model_done = 1'b0;
   logic [127:0] model_dout = '0;
   logic [127:0] din_hold = '0;
   int           aes_cnt = 0;
   logic         inject_done = 1'b0;
   logic [127:0] inject_dout = '0;
   assign bif.aes_done = model_done | inject_done;
   assign bif.aes_dout = inject_done ? inject_dout : model_dout;

   function automatic logic [127:0] aes_resp(input logic [127:0] d);
      return xor_mode ? (d ^ MASK) : aes_fixed;
   endfunction

   always @(posedge clk) begin
      model_done <= 1'b0;
      if (bif.aes_start && aes_lat > 0) begin
         if (aes_lat == 1) begin
            model_done <= 1'b1;
            model_dout <= aes_resp(bif.aes_din);
         end else begin
            aes_cnt  <= aes_lat - 1;
            din_hold <= bif.aes_din;
         end
      end else if (aes_cnt == 1) begin
         model_done <= 1'b1;
         model_dout <= aes_resp(din_hold);
         aes_cnt    <= 0;
      end else if (aes_cnt > 1) begin
         aes_cnt <= aes_cnt - 1;
      end
   end

   // Monitor
   int           cyc = 0;
   int           rd_count = 0;
   int           st_count = 0;
   int           wr_count = 0;
   int           excl_viol = 0;
   logic [127:0] start_log[$];
   logic [127:0] wr_log[$];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bif.in_read_en) rd_count <= rd_count + 1;
      if (bif.aes_start) begin
         st_count <= st_count + 1;
         start_log.push_back(bif.aes_din);
      end
      if (bif.out_write_en) begin
         wr_count <= wr_count + 1;
         wr_log.push_back(bif.out_din);
      end
      if (!$onehot0({bif.in_read_en, bif.aes_start, bif.out_write_en})) excl_viol <= excl_viol + 1;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [127:0] blk);
      fifo_mem[wr_ptr[3:0]] = blk;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (!busy && k < budget) begin @(negedge clk); k++; end
      while (busy && k < budget) begin @(negedge clk); k++; end
      if (k >= budget) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: no return to idle within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_start(input int budget, input string name);
      int k = 0;
      while (!bif.aes_start && k < budget) begin @(negedge clk); k++; end
      if (k >= budget) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: no aes_start within %0d cycles", name, budget);
      end
   endtask

   typedef struct {
      logic [127:0] blk;
      logic [127:0] res;
      int           lat;
      logic [127:0] exp_out;
      logic [15:0]  exp_bd;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int rd0, st0, wr0, s, t, k, seen;
      logic wrap_pending;
      logic [127:0] sblk[8];

      vecs[0] = '{blk: 128'h00112233445566778899AABBCCDDEEFF, res: 128'h69C4E0D86A7B0430D8CDB78070B4C55A,
                  lat: 10, exp_out: 128'h69C4E0D86A7B0430D8CDB78070B4C55A, exp_bd: 16'd1};
      vecs[1] = '{blk: 128'h3243F6A8885A308D313198A2E0370734, res: 128'h3925841D02DC09FBDC118597196A0B32,
                  lat: 3, exp_out: 128'h3925841D02DC09FBDC118597196A0B32, exp_bd: 16'd2};
      vecs[2] = '{blk: 128'h0, res: 128'h66E94BD4EF8A2C3B884CFA59CA342B2E,
                  lat: TIMEOUT, exp_out: 128'h66E94BD4EF8A2C3B884CFA59CA342B2E, exp_bd: 16'd3};
      vecs[3] = '{blk: 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, res: 128'hA1B2C3D4E5F60718293A4B5C6D7E8F90,
                  lat: 1, exp_out: 128'hA1B2C3D4E5F60718293A4B5C6D7E8F90, exp_bd: 16'd4};

      #1 reset = 1'b1;
      #1;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_read", 128'(bif.in_read_en), 128'(0));
      chk("rst_start", 128'(bif.aes_start), 128'(0));
      chk("rst_write", 128'(bif.out_write_en), 128'(0));
      chk("rst_tmo", 128'(timeout_err), 128'(0));
      chk("rst_blocks", 128'(blocks_done), 128'(0));
      chk("rst_out_din", bif.out_din, 128'h0);
      chk("rst_aes_din", bif.aes_din, 128'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;

      // Plain blocks, including done on the last allowed cycle and a 1-cycle core
      for (int i = 0; i < 4; i++) begin
         rd0 = rd_count; st0 = st_count; wr0 = wr_count;
         aes_lat = vecs[i].lat;
         aes_fixed = vecs[i].res;
         push(vecs[i].blk);
         wait_idle(400, "vec_idle");
         chk("vec_out_din", bif.out_din, vecs[i].exp_out);
         chk("vec_blocks", 128'(blocks_done), 128'(vecs[i].exp_bd));
         chk("vec_reads", 128'(rd_count - rd0), 128'(1));
         chk("vec_starts", 128'(st_count - st0), 128'(1));
         chk("vec_writes", 128'(wr_count - wr0), 128'(1));
         chk("vec_aes_din", bif.aes_din, vecs[i].blk);
         chk("vec_started_with", start_log[st0], vecs[i].blk);
         chk("vec_tmo", 128'(timeout_err), 128'(0));
         $display("vec %0d: in=%h out=%h blocks=%0d", i, vecs[i].blk, bif.out_din, blocks_done);
      end

      // Stray done while idle
      @(negedge clk);
      inject_dout = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      inject_done = 1'b1;
      @(negedge clk);
      inject_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_out_din", bif.out_din, vecs[3].exp_out);
      chk("stray_busy", 128'(busy), 128'(0));
      $display("stray done: out_din=%h busy=%0d", bif.out_din, busy);

      // Backpressure; enable also drops mid-block, which must not abort it
      rd0 = rd_count; wr0 = wr_count;
      ovf = 1'b1;
      aes_lat = 5;
      aes_fixed = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
      push(128'h11111111222222223333333344444444);
      k = 0;
      while (!model_done && k < 200) begin @(negedge clk); k++; end
      if (k >= 200) begin n_chk++; n_err++; $display("FAIL bp_done: core never answered"); end
      enable = 1'b0;
      seen = 0;
      repeat (20) begin @(negedge clk); if (bif.out_write_en) seen++; end
      chk("bp_no_early_write", 128'(seen), 128'(0));
      ovf = 1'b0;
      chk("bp_write_same_cycle", 128'(bif.out_write_en), 128'(0));
      @(negedge clk);
      chk("bp_write_next_cycle", 128'(bif.out_write_en), 128'(1));
      @(negedge clk);
      chk("bp_write_single", 128'(bif.out_write_en), 128'(0));
      wait_idle(50, "bp_idle");
      chk("bp_writes", 128'(wr_count - wr0), 128'(1));
      chk("bp_blocks", 128'(blocks_done), 128'(5));
      chk("bp_out_din", bif.out_din, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
      $display("backpressure: writes=%0d blocks=%0d", wr_count - wr0, blocks_done);

      // Enable low: a queued block is not fetched
      rd0 = rd_count;
      push(128'hAAAA5555AAAA5555AAAA5555AAAA5555);
      repeat (10) @(negedge clk);
      chk("dis_busy", 128'(busy), 128'(0));
      chk("dis_reads", 128'(rd_count - rd0), 128'(0));
      enable = 1'b1;
      aes_lat = 4;
      aes_fixed = 128'h1;
      wait_idle(200, "dis_idle");
      chk("dis_blocks", 128'(blocks_done), 128'(6));
      $display("enable gate: blocks=%0d", blocks_done);

      // Timeout: core never answers
      wr0 = wr_count;
      aes_lat = 0;
      push(128'hC0FFEE00C0FFEE00C0FFEE00C0FFEE00);
      wait_start(100, "tmo_start");
      s = cyc;
      k = 0;
      while (!timeout_err && k < 300) begin @(negedge clk); k++; end
      t = cyc;
      // CRYPT occupies TIMEOUT cycles after the START cycle; the flag is seen in the next one
      chk("tmo_latency", 128'(t - s), 128'(TIMEOUT + 1));
      chk("tmo_flag", 128'(timeout_err), 128'(1));
      chk("tmo_idle", 128'(busy), 128'(0));
      chk("tmo_blocks", 128'(blocks_done), 128'(6));
      repeat (10) @(negedge clk);
      chk("tmo_no_write", 128'(wr_count - wr0), 128'(0));
      chk("tmo_sticky", 128'(timeout_err), 128'(1));
      $display("timeout: cycles=%0d err=%0d", t - s, timeout_err);

      // Empty race during SETTLE
      rd0 = rd_count; st0 = st_count;
      push(128'hBADC0DE0BADC0DE0BADC0DE0BADC0DE0);
      @(negedge clk);
      chk("race_settle_busy", 128'(busy), 128'(1));
      fifo_kill = 1'b1;
      repeat (10) @(negedge clk);
      chk("race_idle", 128'(busy), 128'(0));
      chk("race_reads", 128'(rd_count - rd0), 128'(0));
      chk("race_starts", 128'(st_count - st0), 128'(0));
      $display("empty race: busy=%0d reads=%0d", busy, rd_count - rd0);

      // Reset in CRYPT (the block hidden above is fetched now)
      aes_lat = 10;
      aes_fixed = 128'h77777777777777777777777777777777;
      fifo_kill = 1'b0;
      wait_start(100, "rst_crypt_start");
      repeat (3) @(negedge clk);
      chk("rc_busy_before", 128'(busy), 128'(1));
      reset = 1'b1;
      #1;
      chk("rc_busy", 128'(busy), 128'(0));
      chk("rc_tmo", 128'(timeout_err), 128'(0));
      chk("rc_blocks", 128'(blocks_done), 128'(0));
      chk("rc_out_din", bif.out_din, 128'h0);
      chk("rc_aes_din", bif.aes_din, 128'h0);
      chk("rc_strobes", 128'({bif.in_read_en, bif.aes_start, bif.out_write_en}), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      wr0 = wr_count;
      repeat (20) @(negedge clk);
      chk("rc_late_done_busy", 128'(busy), 128'(0));
      chk("rc_late_done_out", bif.out_din, 128'h0);
      chk("rc_late_done_write", 128'(wr_count - wr0), 128'(0));
      $display("reset in crypt: busy=%0d out_din=%h", busy, bif.out_din);

      // Counter wrap and an eight-block stream
      @(negedge clk);
      force dut.blocks_done = 16'hFFFF;
      @(negedge clk);
      release dut.blocks_done;
      rd0 = rd_count; st0 = st_count; wr0 = wr_count;
      xor_mode = 1'b1;
      aes_lat = 2;
      for (int i = 0; i < 8; i++) begin
         sblk[i] = {32'h1000_0000 + 32'(i), 32'hCAFE_0000 | 32'(i), 32'h0BAD_F00D, 32'(i * 7)};
         push(sblk[i]);
      end
      k = 0; seen = 0; wrap_pending = 1'b0;
      while ((wr_count - wr0) < 8 && k < 3000) begin
         @(negedge clk);
         k++;
         if (wrap_pending) begin
            chk("wrap_first", 128'(blocks_done), 128'(0));
            wrap_pending = 1'b0;
         end
         if (bif.out_write_en && seen == 0) begin
            seen = 1;
            wrap_pending = 1'b1;
         end
      end
      if (k >= 3000) begin n_chk++; n_err++; $display("FAIL stream_budget: %0d writes", wr_count - wr0); end
      repeat (10) @(negedge clk);
      chk("stream_reads", 128'(rd_count - rd0), 128'(8));
      chk("stream_starts", 128'(st_count - st0), 128'(8));
      chk("stream_writes", 128'(wr_count - wr0), 128'(8));
      chk("stream_blocks", 128'(blocks_done), 128'(16'h0007));
      chk("stream_exclusive", 128'(excl_viol), 128'(0));
      for (int i = 0; i < 8; i++) begin
         chk("stream_start_order", start_log[st0 + i], sblk[i]);
         chk("stream_write_order", wr_log[wr0 + i], sblk[i] ^ MASK);
         $display("stream %0d: in=%h out=%h", i, sblk[i], wr_log[wr0 + i]);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
